conv_mac_sequencer: RTL and testbench

- Sequences the 9-lane multiplier/adder-tree datapath for 3x3 convolution.
- Accepts a stream of 3x3 windows (9 signed 8-bit weights and 9 signed 8-bit activations per window).
- Issues one window per cycle to the datapath, injecting the bias only on the first window of each output group.
- Accumulates the returned 19-bit window sums over a configured number of input channels and delivers one accumulated result per group over a valid/ready output port.
- Sits between the window-fetch logic and the activation/writeback stage.

---
 rtl/conv_mac_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_conv_mac_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_sequencer.sv
// Window sequencer for the 9-lane 3x3 convolution datapath: issues one window per
// cycle, tracks in-flight issues, accumulates channel sums and emits one result per group.
module conv_mac_sequencer #(
    parameter int DP_LAT = 2,
    parameter int ACC_W  = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [7:0]       cfg_channels,
    input  logic [15:0]      cfg_groups,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [71:0]      in_weight,
    input  logic [71:0]      in_act,
    input  logic [15:0]      in_bias,
    output logic [71:0]      dp_multiplier9,
    output logic [71:0]      dp_multiplicand9,
    output logic [15:0]      dp_bias,
    output logic             dp_valid,
    input  logic [18:0]      dp_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [8:0]         channels_q, channels_d;
    logic [15:0]        groups_q, groups_d;
    logic [7:0]         chCnt_q, chCnt_d;
    logic [15:0]        grpCnt_q, grpCnt_d;
    logic [DP_LAT:0]    pipeValid_q, pipeValid_d;
    logic [DP_LAT:0]    pipeFirst_q, pipeFirst_d;
    logic [DP_LAT:0]    pipeLast_q, pipeLast_d;
    logic [71:0]        mult_q, mult_d;
    logic [71:0]        mcand_q, mcand_d;
    logic [15:0]        bias_q, bias_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   outData_q, outData_d;
    logic               outValid_q, outValid_d;
    logic [ACC_W-1:0]   skidData_q, skidData_d;
    logic               skidValid_q, skidValid_d;

    logic               accept;
    logic               pendFirst;
    logic               pendLast;
    logic               lastInFlight;
    logic               outBlocked;
    logic               retValid;
    logic               pipeEmpty;
    logic [ACC_W-1:0]   sumExt;
    logic [ACC_W-1:0]   sum;

    // Stage 0 of the pipe is the issue register itself; stage DP_LAT lines up with dp_sum.
    // A returning last entry may be overtaken by the next last window, so a one-entry
    // skid catches a result that lands while the output register is still held.
    assign pendFirst    = (chCnt_q == 8'd0);
    assign pendLast     = ({1'b0, chCnt_q} == (channels_q - 9'd1));
    assign lastInFlight = |(pipeValid_q[DP_LAT-1:0] & pipeLast_q[DP_LAT-1:0]);
    assign outBlocked   = (outValid_q && !out_ready) || skidValid_q;
    assign in_ready     = (state_q == RUN) && !(pendLast && (lastInFlight || outBlocked));
    assign accept       = in_valid && in_ready;
    assign retValid     = pipeValid_q[DP_LAT];
    assign pipeEmpty    = ~|pipeValid_q;
    assign sumExt       = {{(ACC_W-19){dp_sum[18]}}, dp_sum};
    assign sum          = sumExt + (pipeFirst_q[DP_LAT] ? {ACC_W{1'b0}} : acc_q);

    assign busy             = (state_q != IDLE);
    assign dp_valid         = pipeValid_q[0];
    assign dp_multiplier9   = mult_q;
    assign dp_multiplicand9 = mcand_q;
    assign dp_bias          = bias_q;
    assign out_valid        = outValid_q;
    assign out_data         = outData_q;

    always_comb begin
        state_d     = state_q;
        channels_d  = channels_q;
        groups_d    = groups_q;
        chCnt_d     = chCnt_q;
        grpCnt_d    = grpCnt_q;
        mult_d      = mult_q;
        mcand_d     = mcand_q;
        bias_d      = bias_q;
        acc_d       = acc_q;
        outData_d   = outData_q;
        outValid_d  = outValid_q;
        skidData_d  = skidData_q;
        skidValid_d = skidValid_q;
        pipeValid_d = {pipeValid_q[DP_LAT-1:0], accept};
        pipeFirst_d = {pipeFirst_q[DP_LAT-1:0], pendFirst};
        pipeLast_d  = {pipeLast_q[DP_LAT-1:0], pendLast};

        case (state_q)
            IDLE: begin
                if (cfg_valid && (cfg_groups != 16'd0)) begin
                    channels_d = (cfg_channels == 8'd0) ? 9'd256 : {1'b0, cfg_channels};
                    groups_d   = cfg_groups;
                    chCnt_d    = 8'd0;
                    grpCnt_d   = 16'd0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    mult_d  = in_weight;
                    mcand_d = in_act;
                    bias_d  = pendFirst ? in_bias : 16'd0;
                    chCnt_d = pendLast ? 8'd0 : chCnt_q + 8'd1;
                    if (pendLast) begin
                        grpCnt_d = grpCnt_q + 16'd1;
                        if (grpCnt_q == (groups_q - 16'd1)) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (pipeEmpty && (!outValid_q || (out_ready && !skidValid_q))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (outValid_q && out_ready) begin
            if (skidValid_q) begin
                outData_d   = skidData_q;
                skidValid_d = 1'b0;
            end else begin
                outValid_d = 1'b0;
            end
        end

        // A returning result lands after any drain, so a same-cycle load keeps out_valid high.
        if (retValid) begin
            if (pipeLast_q[DP_LAT]) begin
                acc_d = {ACC_W{1'b0}};
                if (!outValid_d) begin
                    outData_d  = sum;
                    outValid_d = 1'b1;
                end else begin
                    skidData_d  = sum;
                    skidValid_d = 1'b1;
                end
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            channels_q  <= 9'd0;
            groups_q    <= 16'd0;
            chCnt_q     <= 8'd0;
            grpCnt_q    <= 16'd0;
            pipeValid_q <= '0;
            pipeFirst_q <= '0;
            pipeLast_q  <= '0;
            mult_q      <= 72'd0;
            mcand_q     <= 72'd0;
            bias_q      <= 16'd0;
            acc_q       <= '0;
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            skidData_q  <= '0;
            skidValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            channels_q  <= channels_d;
            groups_q    <= groups_d;
            chCnt_q     <= chCnt_d;
            grpCnt_q    <= grpCnt_d;
            pipeValid_q <= pipeValid_d;
            pipeFirst_q <= pipeFirst_d;
            pipeLast_q  <= pipeLast_d;
            mult_q      <= mult_d;
            mcand_q     <= mcand_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            outData_q   <= outData_d;
            outValid_q  <= outValid_d;
            skidData_q  <= skidData_d;
            skidValid_q <= skidValid_d;
        end
    end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench for conv_mac_sequencer: a behavioural datapath feeds dp_sum back,
// expected group results are queued at stimulus time and checked by an output monitor.
module tb_conv_mac_sequencer;

    localparam int DP_LAT = 2;
    localparam int ACC_W  = 27;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic [7:0]       cfg_channels;
    logic [15:0]      cfg_groups;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [71:0]      in_weight;
    logic [71:0]      in_act;
    logic [15:0]      in_bias;
    logic [71:0]      dp_multiplier9;
    logic [71:0]      dp_multiplicand9;
    logic [15:0]      dp_bias;
    logic             dp_valid;
    logic [18:0]      dp_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;

    int     checks = 0;
    int     errors = 0;
    int     acceptCount = 0;
    longint expQ[$];
    longint expVal;
    logic [18:0] dpPipe [DP_LAT];

    always #5 clk = ~clk;

    conv_mac_sequencer #(.DP_LAT(DP_LAT), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_channels(cfg_channels), .cfg_groups(cfg_groups),
        .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_weight(in_weight), .in_act(in_act), .in_bias(in_bias),
        .dp_multiplier9(dp_multiplier9), .dp_multiplicand9(dp_multiplicand9),
        .dp_bias(dp_bias), .dp_valid(dp_valid), .dp_sum(dp_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    function automatic longint windowSum(input logic [71:0] w, input logic [71:0] a,
                                         input logic [15:0] b);
        longint s;
        logic signed [7:0] wk;
        logic signed [7:0] ak;
        logic signed [15:0] bs;
        bs = b;
        s = longint'(bs);
        for (int k = 0; k < 9; k++) begin
            wk = w[8*k +: 8];
            ak = a[8*k +: 8];
            s += longint'(wk) * longint'(ak);
        end
        return s;
    endfunction

    function automatic longint wrapAcc(input longint v);
        logic signed [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return longint'(t);
    endfunction

    function automatic logic [71:0] rep9(input logic [7:0] v);
        return {9{v}};
    endfunction

    // Behavioural 9-lane multiplier/adder tree with DP_LAT cycles of latency.
    always @(posedge clk) begin
        longint s;
        s = windowSum(dp_multiplier9, dp_multiplicand9, dp_bias);
        dpPipe[0] <= s[18:0];
        for (int i = 1; i < DP_LAT; i++) dpPipe[i] <= dpPipe[i-1];
    end
    assign dp_sum = dpPipe[DP_LAT-1];

    task automatic checkOutput(input string name, input longint actual, input longint required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Scoreboard monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedResult actual=%0d required=none",
                         longint'($signed(out_data)));
            end else begin
                expVal = expQ.pop_front();
                checkOutput("groupResult", longint'($signed(out_data)), expVal);
            end
        end
        if (!reset && in_valid && in_ready) acceptCount++;
    end

    task automatic applyStimulus(input logic [71:0] w, input logic [71:0] a,
                                 input logic [15:0] b, output int stalls);
        in_weight = w;
        in_act    = a;
        in_bias   = b;
        in_valid  = 1'b1;
        stalls    = 0;
        @(negedge clk);
        while (!in_ready && stalls < 300) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout actual=stalled required=accepted");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic startJob(input logic [7:0] ch, input logic [15:0] grp);
        cfg_channels = ch;
        cfg_groups   = grp;
        cfg_valid    = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idleTimeout", longint'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stalls;
        int n;
        int base;
        int totalStalls;
        longint gsum;
        logic [71:0] sw;
        logic [71:0] sa;
        logic [15:0] sb;

        reset = 1'b1;
        cfg_valid = 1'b0; cfg_channels = 8'd0; cfg_groups = 16'd0;
        in_valid = 1'b0; in_weight = 72'd0; in_act = 72'd0; in_bias = 16'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", longint'(busy), 0);
        checkOutput("rstInReady", longint'(in_ready), 0);
        checkOutput("rstDpValid", longint'(dp_valid), 0);
        checkOutput("rstOutValid", longint'(out_valid), 0);
        checkOutput("rstOutData", longint'($signed(out_data)), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single window: 9*3*2 + 5 = 59
        $display("[TB] single window");
        startJob(8'd1, 16'd1);
        expQ.push_back(59);
        applyStimulus(rep9(8'd3), rep9(8'd2), 16'd5, stalls);
        checkOutput("issueLatency", longint'(dp_valid), 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("resultLatency", longint'(n), longint'(DP_LAT + 1));
        @(posedge clk);
        #1;
        checkOutput("busyAfterAccept", longint'(busy), 0);

        // Signed extremes: 147456-7 + 2*147456 = 442361
        $display("[TB] multi-channel signed extremes");
        startJob(8'd3, 16'd1);
        expQ.push_back(442361);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(rep9(8'h80), rep9(8'h80), 16'hFFF9, stalls);
            checkOutput("dpBias", longint'($signed(dp_bias)), (i == 0) ? -7 : 0);
        end
        checkOutput("dpMultLane8", longint'($signed(dp_multiplier9[71:64])), -128);
        waitIdle(50);

        // Streaming: 4 channels x 5 groups, random operands, no stalls expected
        $display("[TB] streaming throughput");
        startJob(8'd4, 16'd5);
        base = acceptCount;
        totalStalls = 0;
        gsum = 0;
        for (int i = 0; i < 20; i++) begin
            sw[31:0] = $urandom(); sw[63:32] = $urandom(); sw[71:64] = 8'($urandom());
            sa[31:0] = $urandom(); sa[63:32] = $urandom(); sa[71:64] = 8'($urandom());
            sb = 16'($urandom());
            if (i % 4 == 0) gsum = windowSum(sw, sa, sb);
            else gsum += windowSum(sw, sa, 16'd0);
            if (i % 4 == 3) expQ.push_back(wrapAcc(gsum));
            applyStimulus(sw, sa, sb, stalls);
            totalStalls += stalls;
        end
        checkOutput("streamStalls", longint'(totalStalls), 0);
        checkOutput("streamAccepts", longint'(acceptCount - base), 20);
        waitIdle(50);

        // Backpressure: results 9, 28, 47, 66
        $display("[TB] backpressure");
        out_ready = 1'b0;
        startJob(8'd1, 16'd4);
        for (int g = 0; g < 4; g++) expQ.push_back(longint'(9 * (g + 1) + 10 * g));
        base = acceptCount;
        fork
            begin
                int st;
                for (int g = 0; g < 4; g++)
                    applyStimulus(rep9(8'(g + 1)), rep9(8'd1), 16'(10 * g), st);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                checkOutput("bpAccepts", longint'(acceptCount - base), 2);
                checkOutput("bpInReady", longint'(in_ready), 0);
                checkOutput("bpHeldData", longint'($signed(out_data)), 9);
                out_ready = 1'b1;
            end
        join
        waitIdle(100);

        // Mid-job reset with windows in flight
        $display("[TB] mid-job reset");
        startJob(8'd3, 16'd2);
        applyStimulus(rep9(8'd5), rep9(8'd7), 16'd33, stalls);
        applyStimulus(rep9(8'd6), rep9(8'd7), 16'd0, stalls);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstBusy", longint'(busy), 0);
        checkOutput("midRstInReady", longint'(in_ready), 0);
        checkOutput("midRstDpValid", longint'(dp_valid), 0);
        checkOutput("midRstDpMult", longint'(dp_multiplier9 != 72'd0), 0);
        checkOutput("midRstOutValid", longint'(out_valid), 0);
        checkOutput("midRstOutData", longint'($signed(out_data)), 0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("postRstOutValid", longint'(out_valid), 0);

        // Clean job with a stray cfg_valid in RUN: 109 + (-18) = 91
        startJob(8'd2, 16'd1);
        expQ.push_back(91);
        applyStimulus(rep9(8'd1), rep9(8'd1), 16'd100, stalls);
        startJob(8'd1, 16'd5);
        checkOutput("cfgIgnoredBusy", longint'(busy), 1);
        applyStimulus(rep9(8'hFF), rep9(8'd2), 16'd50, stalls);
        waitIdle(50);

        // Zero-encoded configuration
        $display("[TB] zero-encoded configuration");
        startJob(8'd1, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("zeroGroupsBusy", longint'(busy), 0);
        checkOutput("zeroGroupsInReady", longint'(in_ready), 0);
        startJob(8'd0, 16'd2);
        expQ.push_back(2311);
        expQ.push_back(-2307);
        for (int i = 0; i < 512; i++) begin
            sb = (i < 256) ? 16'd7 : 16'hFFFD;
            applyStimulus(rep9(8'd1), (i < 256) ? rep9(8'd1) : rep9(8'hFF), sb, stalls);
            if (i == 0 || i == 1 || i == 255 || i == 256 || i == 257)
                checkOutput("ch256Bias", longint'($signed(dp_bias)),
                            (i % 256 == 0) ? longint'($signed(sb)) : 0);
        end
        waitIdle(50);

        checkOutput("queueEmpty", longint'(expQ.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
